// File: rtl/math_div_unit_pkg.sv
// math_div_unit_pkg: shared state encoding for the restoring divider
package math_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/math_div_unit_div_step.sv
// math_div_unit_div_step: one combinational restoring-division step
module math_div_unit_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);

    // Trial is WIDTH+1 bits wide so a partial remainder with its MSB set is not truncated
    logic [WIDTH:0] w_trial;

    assign w_trial = {partial_rem, dividend_bit};
    assign q_bit   = (w_trial >= {1'b0, divisor});
    // When the subtraction is skipped the trial is below the divisor, so it fits in WIDTH bits
    assign new_rem = q_bit ? WIDTH'(w_trial - {1'b0, divisor}) : w_trial[WIDTH-1:0];

endmodule

// File: rtl/math_div_unit.sv
// math_div_unit: sequential unsigned restoring divider, one quotient bit per clock
module math_div_unit
    import math_div_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;

    math_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
        .partial_rem (r_rem),
        .dividend_bit(r_dvd[WIDTH-1]),
        .divisor     (r_dvs),
        .new_rem     (w_rem_next),
        .q_bit       (w_q_bit)
    );

    // Control FSM; r_dvd shifts the dividend out of its MSB while quotient bits enter its LSB
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        r_dvs    <= divisor;
                        div_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            r_dvd   <= '1;
                            r_rem   <= dividend;
                            r_state <= DIV_FIN;
                        end else begin
                            r_dvd   <= dividend;
                            r_rem   <= '0;
                            r_cnt   <= CW'(WIDTH - 1);
                            r_state <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= DIV_FIN;
                end
                DIV_FIN: begin
                    quotient  <= r_dvd;
                    remainder <= r_rem;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= DIV_IDLE;
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_math_div_unit.sv
// tb_math_div_unit: scoreboard bench for the restoring divider
module tb_math_div_unit;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    math_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .quotient (quotient),
        .remainder(remainder)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = W + 1;
        end
        return e;
    endfunction

    // Push the expected result, issue a one-cycle start, count edges until done (bounded)
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int n, output logic b0);
        sb.push_back(model(a, b));
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b0 = busy;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b1; dividend = 16'd77; divisor = 16'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        checks++; if (quotient !== 16'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", quotient); end
        checks++; if (remainder !== 16'd0) begin failures++; $display("FAIL reset_r got=%0d exp=0", remainder); end
        @(negedge clk);
        start = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_normal();
        logic [W-1:0] ta [6] = '{16'd1000, 16'hFFFF, 16'hFFFF, 16'd3, 16'd0, 16'd12345};
        logic [W-1:0] tb [6] = '{16'd7, 16'd1, 16'hFFFF, 16'd10, 16'd9, 16'h8001};
        int n;
        logic b0;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            run_div(ta[i], tb[i], n, b0);
            e = sb.pop_front();
            checks++; if (!done || n != e.lat) begin failures++; $display("FAIL norm%0d_latency got=%0d exp=%0d done=%b", i, n, e.lat, done); end
            checks++; if (quotient !== e.q) begin failures++; $display("FAIL norm%0d_q got=%0d exp=%0d", i, quotient, e.q); end
            checks++; if (remainder !== e.r) begin failures++; $display("FAIL norm%0d_r got=%0d exp=%0d", i, remainder, e.r); end
            checks++; if (div_zero !== e.dz) begin failures++; $display("FAIL norm%0d_dz got=%b exp=%b", i, div_zero, e.dz); end
            checks++; if (b0 !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL norm%0d_busy got=%b/%b exp=1/0", i, b0, busy); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL norm%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_div_zero();
        int n;
        logic b0;
        exp_t e;
        run_div(16'd5, 16'd0, n, b0);
        e = sb.pop_front();
        checks++; if (!done || n != e.lat) begin failures++; $display("FAIL dz_latency got=%0d exp=%0d done=%b", n, e.lat, done); end
        checks++; if (quotient !== e.q || remainder !== e.r) begin failures++; $display("FAIL dz_result got=%0d/%0d exp=%0d/%0d", quotient, remainder, e.q, e.r); end
        checks++; if (div_zero !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL dz_flags got dz=%b busy=%b exp dz=1 busy=0", div_zero, busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_held got=%b exp=1", div_zero); end
        run_div(16'd9, 16'd3, n, b0);
        e = sb.pop_front();
        checks++; if (!done || n != e.lat) begin failures++; $display("FAIL dz_next_latency got=%0d exp=%0d", n, e.lat); end
        checks++; if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin failures++; $display("FAIL dz_next_result got=%0d/%0d/%b exp=%0d/%0d/%b", quotient, remainder, div_zero, e.q, e.r, e.dz); end
    endtask

    task automatic test_start_busy();
        int pulses = 0;
        int first = -1;
        logic [W-1:0] q = '0;
        logic [W-1:0] r = '0;
        exp_t e;
        sb.push_back(model(16'd100, 16'd9));
        @(negedge clk);
        dividend = 16'd100; divisor = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dividend = 16'd50; divisor = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 4; k < 45; k++) begin
            @(posedge clk); #1;
            checks++; if (busy && done) begin failures++; $display("FAIL busy_done_overlap edge=%0d got=1 exp=0", k + 1); end
            if (done) begin
                pulses++;
                if (first < 0) begin first = k + 1; q = quotient; r = remainder; end
            end
        end
        e = sb.pop_front();
        checks++; if (pulses != 1) begin failures++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
        checks++; if (first != e.lat) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", first, e.lat); end
        checks++; if (q !== e.q || r !== e.r) begin failures++; $display("FAIL busy_result got=%0d/%0d exp=%0d/%0d", q, r, e.q, e.r); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int n;
        logic b0;
        exp_t e;
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%b%b%b exp=000", busy, done, div_zero); end
        checks++; if (quotient !== 16'd0 || remainder !== 16'd0) begin failures++; $display("FAIL rmid_outputs got=%0d/%0d exp=0/0", quotient, remainder); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", pulses); end
        run_div(16'd200, 16'd13, n, b0);
        e = sb.pop_front();
        checks++; if (!done || n != e.lat) begin failures++; $display("FAIL rmid_next_latency got=%0d exp=%0d", n, e.lat); end
        checks++; if (quotient !== e.q || remainder !== e.r) begin failures++; $display("FAIL rmid_next_result got=%0d/%0d exp=%0d/%0d", quotient, remainder, e.q, e.r); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        exp_t e;
        sb.push_back(model(16'd30, 16'd4));
        sb.push_back(model(16'd45, 16'd4));
        @(negedge clk);
        dividend = 16'd30; divisor = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        dividend = 16'd45;
        while (!done && n < 60) begin @(posedge clk); #1; n++; end
        e = sb.pop_front();
        checks++; if (!done || n != e.lat) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", n, e.lat); end
        checks++; if (quotient !== e.q || remainder !== e.r) begin failures++; $display("FAIL b2b_first_result got=%0d/%0d exp=%0d/%0d", quotient, remainder, e.q, e.r); end
        n = 0;
        @(posedge clk); #1; n++;
        while (!done && n < 60) begin @(posedge clk); #1; n++; end
        start = 1'b0;
        e = sb.pop_front();
        checks++; if (!done || n != e.lat + 1) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", n, e.lat + 1); end
        checks++; if (quotient !== e.q || remainder !== e.r) begin failures++; $display("FAIL b2b_second_result got=%0d/%0d exp=%0d/%0d", quotient, remainder, e.q, e.r); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_div_zero();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
